// File: rtl/pe_acc_offset.sv
// rtl/pe_acc_offset.sv - offset-seeded signed product accumulator; PE_ACC_SAT_EN selects saturating arithmetic
module pe_acc_offset #(
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32,
    parameter int CNT_BW = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            gemm_uno,
    input  logic                  start_i,
    input  logic [CNT_BW-1:0]     len_i,
    input  logic [ACC_BW-1:0]     offset_i,
    input  logic [2*MUL_BW-1:0]   prod_i,
    input  logic                  prod_vld_i,
    output logic                  prod_rdy_o,
    output logic [ACC_BW-1:0]     acc_o,
    output logic                  acc_vld_o,
    input  logic                  acc_rdy_i,
    output logic                  busy_o,
    output logic                  sat_o,
    output logic [1:0]            op_o
);

    typedef enum logic [1:0] {IDLE, LOAD, ACC, DONE} state_t;

    localparam logic [CNT_BW-1:0] CNT_ONE = CNT_BW'(1);

    state_t            state;
    logic [CNT_BW-1:0] len_q;
    logic [CNT_BW-1:0] cnt;
    logic [ACC_BW-1:0] acc_q;
    logic [ACC_BW-1:0] prod_ext;
    logic [ACC_BW-1:0] acc_next;
    logic              ovf;
    logic              take;

    assign prod_ext = ACC_BW'($signed(prod_i));
    assign take     = prod_vld_i && prod_rdy_o;
    assign acc_o    = acc_q;

`ifdef PE_ACC_SAT_EN
    logic [ACC_BW:0] sum_w;

    assign sum_w = {acc_q[ACC_BW-1], acc_q} + {prod_ext[ACC_BW-1], prod_ext};
    assign ovf   = (acc_q[ACC_BW-1] == prod_ext[ACC_BW-1]) &&
                   (sum_w[ACC_BW-1] != acc_q[ACC_BW-1]);

    // The extra sum bit carries the true sign, so it picks the clamp rail.
    always_comb begin
        acc_next = sum_w[ACC_BW-1:0];
        if (ovf)
            acc_next = sum_w[ACC_BW] ? {1'b1, {(ACC_BW-1){1'b0}}}
                                     : {1'b0, {(ACC_BW-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_o <= 1'b0;
        else if (state == IDLE && start_i)
            sat_o <= 1'b0;
        else if (state == ACC && take && ovf)
            sat_o <= 1'b1;
    end
`else
    assign acc_next = acc_q + prod_ext;
    assign ovf      = 1'b0;
    assign sat_o    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_q      <= '0;
            cnt        <= '0;
            acc_q      <= '0;
            op_o       <= 2'b00;
            prod_rdy_o <= 1'b0;
            acc_vld_o  <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        len_q  <= len_i;
                        op_o   <= gemm_uno;
                        busy_o <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    // Offset generator output is registered, so it is valid now.
                    acc_q <= offset_i;
                    cnt   <= '0;
                    if (len_q != '0) begin
                        prod_rdy_o <= 1'b1;
                        state      <= ACC;
                    end else begin
                        acc_vld_o <= 1'b1;
                        state     <= DONE;
                    end
                end
                ACC: begin
                    if (take) begin
                        acc_q <= acc_next;
                        cnt   <= cnt + CNT_ONE;
                        if (cnt == len_q - CNT_ONE) begin
                            prod_rdy_o <= 1'b0;
                            acc_vld_o  <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (acc_rdy_i) begin
                        acc_vld_o <= 1'b0;
                        busy_o    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_acc_offset.sv
// tb/tb_pe_acc_offset.sv - scoreboard bench for pe_acc_offset with a longint arithmetic reference
module tb_pe_acc_offset;

    localparam int MUL_BW = 16;
    localparam int ACC_BW = 32;
    localparam int CNT_BW = 6;

    logic                clk;
    logic                rst_n;
    logic [1:0]          gemm_uno;
    logic                start_i;
    logic [CNT_BW-1:0]   len_i;
    logic [ACC_BW-1:0]   offset_i;
    logic [2*MUL_BW-1:0] prod_i;
    logic                prod_vld_i;
    logic                prod_rdy_o;
    logic [ACC_BW-1:0]   acc_o;
    logic                acc_vld_o;
    logic                acc_rdy_i;
    logic                busy_o;
    logic                sat_o;
    logic [1:0]          op_o;

    pe_acc_offset #(.MUL_BW(MUL_BW), .ACC_BW(ACC_BW), .CNT_BW(CNT_BW)) dut (
        .clk(clk), .rst_n(rst_n), .gemm_uno(gemm_uno), .start_i(start_i),
        .len_i(len_i), .offset_i(offset_i), .prod_i(prod_i), .prod_vld_i(prod_vld_i),
        .prod_rdy_o(prod_rdy_o), .acc_o(acc_o), .acc_vld_o(acc_vld_o),
        .acc_rdy_i(acc_rdy_i), .busy_o(busy_o), .sat_o(sat_o), .op_o(op_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] acc;
        logic        sat;
        logic [1:0]  op;
    } exp_t;

    exp_t               exp_q[$];
    int                 vectors = 0;
    int                 errors  = 0;
    int                 force_hold = 0;
    bit                 pulse_all = 0;
    logic signed [31:0] prods[64];
    int                 bub[64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact integer sum, then clamp (saturating) or reduce mod 2^32 per term.
    function automatic exp_t model(input logic [1:0] op, input int len, input logic [31:0] off);
        exp_t   r;
        longint a  = longint'($signed(off));
        longint hi = 64'sd2147483647;
        longint lo = -64'sd2147483648;
        bit     s  = 1'b0;
        for (int i = 0; i < len; i++) begin
            a = a + longint'(prods[i]);
`ifdef PE_ACC_SAT_EN
            if (a > hi) begin a = hi; s = 1'b1; end
            else if (a < lo) begin a = lo; s = 1'b1; end
`else
            a = longint'($signed(a[31:0]));
            if (a > hi || a < lo) s = 1'b1;
`endif
        end
`ifndef PE_ACC_SAT_EN
        s = 1'b0;
`endif
        r.acc = a[31:0];
        r.sat = s;
        r.op  = op;
        return r;
    endfunction

    // Monitor: pops on each new result, checks stability while backpressured.
    initial begin : monitor
        exp_t        e;
        bit          seen = 1'b0;
        bit          hs   = 1'b0;
        int          hold = 0;
        logic [31:0] held = '0;
        acc_rdy_i = 1'b0;
        forever begin
            @(negedge clk);
            if (hs || !rst_n) seen = 1'b0;
            if (acc_vld_o) begin
                if (!seen) begin
                    seen = 1'b1;
                    held = acc_o;
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("acc_o", acc_o, e.acc);
                        check("sat_o", {31'd0, sat_o}, {31'd0, e.sat});
                        check("op_o", {30'd0, op_o}, {30'd0, e.op});
                    end
                    if (force_hold > 0) begin
                        hold = force_hold;
                        force_hold = 0;
                    end else begin
                        hold = $urandom % 4;
                    end
                end else begin
                    check("acc_stable", acc_o, held);
                end
                if (hold > 0) begin
                    acc_rdy_i = 1'b0;
                    hold--;
                end else begin
                    acc_rdy_i = 1'b1;
                end
            end else begin
                acc_rdy_i = $urandom % 2;
            end
            hs = acc_vld_o && acc_rdy_i;
        end
    end

    task automatic run_op(input logic [1:0] op, input int len, input logic [31:0] off);
        int cyc = 0;
        int to;
        bit no_bub = 1'b1;
        for (int i = 0; i < len; i++) if (bub[i] != 0) no_bub = 1'b0;
        exp_q.push_back(model(op, len, off));
        start_i  = 1'b1;
        gemm_uno = op;
        len_i    = CNT_BW'(len);
        @(negedge clk); cyc++;
        start_i  = 1'b0;
        len_i    = CNT_BW'($urandom);
        gemm_uno = 2'($urandom);
        offset_i = off;
        for (int i = 0; i < len; i++) begin
            for (int b = 0; b < bub[i]; b++) begin
                prod_vld_i = 1'b0;
                prod_i     = $urandom;
                @(negedge clk); cyc++;
            end
            prod_vld_i = 1'b1;
            prod_i     = prods[i];
            to = 0;
            while (!prod_rdy_o && to < 20) begin
                @(negedge clk); cyc++; to++;
            end
            if (to >= 20) check("prod_rdy_timeout", 32'd1, 32'd0);
            @(negedge clk); cyc++;
            offset_i = $urandom;
        end
        prod_vld_i = 1'b0;
        prod_i     = $urandom;
        to = 0;
        while (!acc_vld_o && to < 200) begin
            @(negedge clk); cyc++; to++;
        end
        if (to >= 200) check("acc_vld_timeout", 32'd1, 32'd0);
        if (no_bub) check("latency", 32'(cyc), 32'(len + 2));
        check("prod_rdy_in_done", {31'd0, prod_rdy_o}, 32'd0);
        to = 0;
        while (busy_o && to < 200) begin
            if (acc_vld_o && (pulse_all || ($urandom % 3 == 0))) begin
                start_i  = 1'b1;
                gemm_uno = 2'($urandom);
                len_i    = CNT_BW'($urandom);
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk); to++;
        end
        start_i = 1'b0;
        if (to >= 200) check("busy_timeout", 32'd1, 32'd0);
        check("op_hold_idle", {30'd0, op_o}, {30'd0, op});
    endtask

    task automatic reset_mid_acc();
        for (int i = 0; i < 5; i++) prods[i] = 32'sd7 + i;
        start_i  = 1'b1;
        gemm_uno = 2'b10;
        len_i    = CNT_BW'(5);
        @(negedge clk);
        start_i  = 1'b0;
        offset_i = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            prod_vld_i = 1'b1;
            prod_i     = prods[i];
            while (!prod_rdy_o) @(negedge clk);
            @(negedge clk);
        end
        prod_vld_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_acc_o", acc_o, 32'd0);
        check("rst_acc_vld", {31'd0, acc_vld_o}, 32'd0);
        check("rst_prod_rdy", {31'd0, prod_rdy_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_sat", {31'd0, sat_o}, 32'd0);
        check("rst_op", {30'd0, op_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", {31'd0, busy_o}, 32'd0);
        check("post_rst_prod_rdy", {31'd0, prod_rdy_o}, 32'd0);
    endtask

    initial begin : driver
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic [31:0]        off;
        int                 len;
        int                 to;
        rst_n = 1'b0; start_i = 1'b0; gemm_uno = 2'b00; len_i = '0;
        offset_i = '0; prod_i = '0; prod_vld_i = 1'b0;
        for (int i = 0; i < 64; i++) begin prods[i] = '0; bub[i] = 0; end
        repeat (3) @(negedge clk);
        check("reset_acc_o", acc_o, 32'd0);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_acc_vld", {31'd0, acc_vld_o}, 32'd0);
        check("reset_prod_rdy", {31'd0, prod_rdy_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        prods[0] = 3; prods[1] = -5; prods[2] = 100; prods[3] = 2;
        run_op(2'b00, 4, 32'd0);

        prods[0] = 32'h10; prods[1] = 32'h20; bub[1] = 2;
        run_op(2'b11, 2, 32'h0000_1000);
        bub[1] = 0;

        run_op(2'b01, 0, 32'h0000_2B80);

        for (int i = 0; i < 3; i++) prods[i] = $urandom;
        force_hold = 5;
        pulse_all  = 1'b1;
        run_op(2'b10, 3, $urandom);
        pulse_all  = 1'b0;

        prods[0] = 32'h20;
        run_op(2'b10, 1, 32'h7FFF_FFF0);

        reset_mid_acc();

        for (int n = 0; n < 40; n++) begin
            len = ($urandom % 8 == 0) ? $urandom_range(40, 63) : $urandom % 13;
            case ($urandom % 4)
                0: off = 32'h7FF0_0000 + ($urandom % 32'h0010_0000);
                1: off = 32'h8000_0000 + ($urandom % 32'h0010_0000);
                default: off = $urandom;
            endcase
            for (int i = 0; i < len; i++) begin
                x = 16'($urandom);
                y = 16'($urandom);
                prods[i] = x * y;
                bub[i] = ($urandom % 10 < 3) ? $urandom_range(1, 3) : 0;
            end
            run_op(2'($urandom), len, off);
        end
        for (int i = 0; i < 64; i++) bub[i] = 0;

        to = 0;
        while (exp_q.size() != 0 && to < 100) begin
            @(negedge clk); to++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pe_acc_offset.md
Name: pe_acc_offset

Overview:
Accumulation stage directly downstream of the PE offset generator.
- Latches the registered offset for the current operation as the accumulator seed.
- Accumulates a programmable number of signed multiplier products into an ACC_BW accumulator.
- Returns the result over a valid/ready handshake.
- Serves all PE modes: gemm dot-product, and the series terms for div/exp/log.

Parameters:
MUL_BW, 16, multiplier operand width; the product is 2*MUL_BW bits.
ACC_BW, 32, accumulator and offset width; must be >= 2*MUL_BW.
CNT_BW, 6, term-count width; at most 2^CNT_BW-1 terms per operation.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
gemm_uno  in  2  op select: 00 gemm, 01 div, 10 exp, 11 log; sampled with start_i
start_i  in  1  start a new operation; accepted only in IDLE
len_i  in  CNT_BW  number of products to accumulate; sampled with start_i
offset_i  in  ACC_BW  signed offset from the offset generator; valid 1 cycle after start_i
prod_i  in  2*MUL_BW  signed product term
prod_vld_i  in  1  product valid
prod_rdy_o  out  1  product ready
acc_o  out  ACC_BW  signed accumulated result
acc_vld_o  out  1  result valid
acc_rdy_i  in  1  result consumed
busy_o  out  1  high in every state except IDLE
sat_o  out  1  sticky saturation flag for the current operation
op_o  out  2  gemm_uno latched at start_i, held until the next accepted start

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; acc_o=0, acc_vld_o=0, prod_rdy_o=0, busy_o=0, sat_o=0, op_o=0, term counter=0.
- Reset mid-operation aborts immediately and returns to the reset state. No partial result is presented.
- Controller FSM has states IDLE, LOAD, ACC, DONE.
- IDLE:
  - On start_i: latch len_i and gemm_uno, clear sat_o, go to LOAD.
  - start_i in any other state is ignored.
- LOAD (exactly 1 cycle):
  - acc <= offset_i. This aligns with the offset generator's 1-cycle registered latency.
  - Go to ACC if the latched len is nonzero, otherwise go to DONE.
- ACC:
  - prod_rdy_o=1.
  - Each cycle with prod_vld_i && prod_rdy_o: acc <= acc + sign_extend(prod_i), counter++.
  - When the last term is accepted (counter == len-1), go to DONE next cycle.
  - Bubbles (prod_vld_i=0) stall without changing acc.
- DONE:
  - acc_vld_o=1, acc_o=acc, prod_rdy_o=0.
  - acc_o stays stable until acc_rdy_i.
  - On acc_vld_o && acc_rdy_i: go to IDLE and drop acc_vld_o next cycle.
  - A start_i in that same cycle is ignored, because the FSM is not in IDLE.
- Latency: start_i to acc_vld_o is 2 + len cycles with no bubbles (LOAD, len ACC cycles, then DONE).
- Arithmetic:
  - The sum is computed at ACC_BW+1 bits.
  - Overflow is detected when the two operands have the same sign and the result sign differs.
  - Overflow handling is set by the optional feature.
- acc_o is registered; it updates only on LOAD and on accepted products.

Optional Feature:
Macro PE_ACC_SAT_EN.
- Defined:
  - On positive overflow, acc clamps to 2^(ACC_BW-1)-1; on negative overflow, to -2^(ACC_BW-1).
  - sat_o is set sticky until the next accepted start_i.
  - Further terms accumulate from the clamped value.
- Undefined:
  - Two's-complement wrap-around modulo 2^ACC_BW.
  - sat_o tied to 0.

Test Plan:
- Reset and idle: assert rst_n=0 mid-ACC after 3 of 5 terms -> all outputs 0 the same cycle; after release, busy_o=0 and prod_rdy_o=0.
- Gemm: start with len=4, offset_i=0, products 3, -5, 100, 2 with no bubbles -> acc_vld_o asserted 6 cycles after start with acc_o=100, sat_o=0.
- Log offset seed with bubbles: gemm_uno=11, offset_i=0x00001000, len=2, products 0x10 and 0x20 with 2 idle cycles between them -> acc_o=0x00001030; prod_rdy_o falls exactly after the 2nd accepted term.
- len=0: start with offset_i=0x2B80 -> DONE entered directly after LOAD; acc_o=0x2B80 valid 2 cycles after start.
- Backpressure and ignored start: hold acc_rdy_i=0 for 5 cycles, pulsing start_i -> acc_o stable, no restart; acc_rdy_i=1 returns to IDLE and the next start is accepted.
- Overflow: offset_i=0x7FFFFFF0, len=1, prod=0x20 -> with PE_ACC_SAT_EN: acc_o=0x7FFFFFFF, sat_o=1; without: acc_o=0x80000010, sat_o=0.
